apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers on pSel/pEnable/pWrite/pAddr/pWdata.
- Returns read data and error status on a valid/ready response stream.
- Sits between a CPU-side or command-parser block and the UART register bank, which is the APB responder.
- One transfer outstanding at a time, with a bus-hang timeout.

Parameters:
- ADDR_W, 32, width of pAddr/cmd_addr
- DATA_W, 32, width of pWdata/pReadData/cmd_wdata/rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles waiting for pReady before abort (minimum 1)

Ports:
- pClk  in  1  clock
- pReset  in  1  reset; one clock; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at posedge
- rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
- rsp_err  out  1  pSlvErr or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- pSel  out  1  APB select
- pEnable  out  1  APB enable
- pWrite  out  1  APB direction
- pAddr  out  ADDR_W  APB address
- pWdata  out  DATA_W  APB write data
- pReadData  in  DATA_W  APB read data
- pReady  in  1  responder ready
- pSlvErr  in  1  responder error
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered. Reset (pReset=0, asynchronous) forces:
  - state=IDLE
  - cmd_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0
  - pSel=0, pEnable=0, pWrite=0, pAddr=0, pWdata=0
  - busy=0, timeout counter=0
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch write/addr/wdata onto pWrite/pAddr/pWdata; pSel<=1, pEnable<=0; cmd_ready<=0; go to SETUP.
- SETUP (exactly 1 cycle): pEnable<=1; clear counter; go to ACCESS.
- ACCESS:
  - pSel=1 and pEnable=1; pWrite/pAddr/pWdata held stable.
  - If pReady=1 at posedge:
    - rsp_rdata<=pWrite ? 0 : pReadData
    - rsp_err<=pSlvErr, rsp_timeout<=0
    - pSel<=0, pEnable<=0, rsp_valid<=1
    - go to RESP
  - Else the counter increments. When the counter reaches TIMEOUT-1 without pReady:
    - abort with rsp_rdata<=0, rsp_err<=1, rsp_timeout<=1
    - pSel<=0, pEnable<=0, rsp_valid<=1
    - go to RESP
  - pReady is sampled only in ACCESS; pReady in IDLE/SETUP is ignored.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid<=0, cmd_ready<=1, go to IDLE.
- No back-to-back acceptance: a new command is accepted at the earliest one cycle after the response is consumed. Minimum cycle per transfer is 4 clocks.
- Latency with a zero-wait responder: command accepted at edge N; pSel=1 after N; pEnable=1 after N+1; transfer completes at edge N+2; rsp_valid=1 after N+2.
- pAddr/pWrite/pWdata keep their last values after a transfer, so no X ever appears on the bus.
- pSlvErr is meaningful only together with pReady.
- Reset mid-transfer drops pSel/pEnable immediately (asynchronously). No response is produced for the aborted command.

Test Plan:
1. Write, zero-wait: cmd write addr=0 wdata=32'd10, pReady tied 1 -> pSel high 2 cycles, pEnable high 1 cycle, pAddr=0, pWdata=10, pWrite=1; rsp_valid 3 cycles after accept; rsp_rdata=0, rsp_err=0.
2. Read with waits: cmd read addr=1; responder asserts pReady on the 3rd ACCESS cycle with pReadData=32'h14 -> pEnable high exactly 3 cycles; rsp_rdata=32'h14, rsp_err=0.
3. Slave error: write addr=3 wdata=32'h00FFFF00; pReady=1 with pSlvErr=1 -> rsp_err=1, rsp_timeout=0; a following read still works.
4. Timeout: TIMEOUT=16, pReady held 0 -> pEnable high exactly 16 cycles, then pSel/pEnable drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
5. Backpressure: rsp_ready held 0 for 10 cycles with cmd_valid held 1 -> cmd_ready=0 and rsp_* stable throughout. The second command is accepted only after the response handshake, and its own SETUP starts one cycle later.
6. Reset mid-ACCESS: pull pReset low while pEnable=1 -> pSel/pEnable/rsp_valid go 0 immediately. After release: cmd_ready=1, busy=0, and a new write completes normally.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB bus signals between apb_cmd_master and its
// surroundings: the master modport is the initiator's view, slave the environment's.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              pSel;
  logic              pEnable;
  logic              pWrite;
  logic [ADDR_W-1:0] pAddr;
  logic [DATA_W-1:0] pWdata;
  logic [DATA_W-1:0] pReadData;
  logic              pReady;
  logic              pSlvErr;

  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  pReadData, pReady, pSlvErr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output pSel, pEnable, pWrite, pAddr, pWdata,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready,
    output pReadData, pReady, pSlvErr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  pSel, pEnable, pWrite, pAddr, pWdata,
    input  busy
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB initiator: one command at a time goes through SETUP/ACCESS, and the result
// comes back on a response stream. An ACCESS that never sees pReady is aborted.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             pClk,
  input  logic             pReset,
  apb_cmd_master_if.master bus
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              busy_q, busy_d;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      busy_q        <= busy_d;
    end
  end

  // Every output is a register, so this block computes their next values;
  // bus address/data are only reloaded on accept and otherwise hold.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;

    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A responder that answers on the final allowed cycle still wins over the abort.
        if (bus.pReady) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.pReadData;
          rsp_err_d     = bus.pSlvErr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.pSel        = psel_q;
  assign bus.pEnable     = penable_q;
  assign bus.pWrite      = pwrite_q;
  assign bus.pAddr       = paddr_q;
  assign bus.pWdata      = pwdata_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a transaction-level model predicts every output each
// cycle from accept time and the responder's chosen wait count.
module tb_apb_cmd_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic pClk = 1'b0;
  logic pReset;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pClk  (pClk),
    .pReset(pReset),
    .bus   (bus.master)
  );

  always #5 pClk = ~pClk;

  int total = 0;
  int bad   = 0;

  // Stimulus controls
  bit                rand_mode = 1'b0;
  int                next_w = 0;
  logic [DATA_W-1:0] dir_rdata = '0;
  logic              dir_slverr = 1'b0;
  logic              dir_rsp_ready = 1'b1;

  // Model: m_k counts edges since accept; pSel spans 1+m_en samples, pEnable m_en of them.
  bit                m_busy = 1'b0;
  int                m_k = 0;
  int                m_w = 0;
  int                m_en = 0;
  logic              m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_err = 1'b0;
  logic              m_to = 1'b0;

  always @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      m_busy  <= 1'b0;
      m_k     <= 0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_write <= bus.cmd_write;
        m_addr  <= bus.cmd_addr;
        m_wdata <= bus.cmd_wdata;
        m_w     <= next_w;
        m_en    <= (next_w + 1 < TIMEOUT) ? next_w + 1 : TIMEOUT;
      end
    end else if (m_k <= 1 + m_en) begin
      if (m_k == 1 + m_en) begin
        if (m_w < TIMEOUT) begin
          m_rdata <= m_write ? '0 : bus.pReadData;
          m_err   <= bus.pSlvErr;
          m_to    <= 1'b0;
        end else begin
          m_rdata <= '0;
          m_err   <= 1'b1;
          m_to    <= 1'b1;
        end
      end
      m_k <= m_k + 1;
    end else if (bus.rsp_ready) begin
      m_busy <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    bit exp_sel, exp_en, exp_rv;
    exp_sel = m_busy && (m_k <= 1 + m_en);
    exp_en  = m_busy && (m_k >= 2) && (m_k <= 1 + m_en);
    exp_rv  = m_busy && (m_k == 2 + m_en);
    checkOutput("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy));
    checkOutput("busy",      64'(bus.busy),      64'(m_busy));
    checkOutput("pSel",      64'(bus.pSel),      64'(exp_sel));
    checkOutput("pEnable",   64'(bus.pEnable),   64'(exp_en));
    checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
    checkOutput("pWrite",    64'(bus.pWrite),    64'(m_write));
    checkOutput("pAddr",     64'(bus.pAddr),     64'(m_addr));
    checkOutput("pWdata",    64'(bus.pWdata),    64'(m_wdata));
    if (exp_rv) begin
      checkOutput("rsp_rdata",   64'(bus.rsp_rdata),   64'(m_rdata));
      checkOutput("rsp_err",     64'(bus.rsp_err),     64'(m_err));
      checkOutput("rsp_timeout", 64'(bus.rsp_timeout), 64'(m_to));
    end
  endtask

  task automatic newRandomCmd();
    int r;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = ADDR_W'($urandom_range(0, 15));
    bus.cmd_wdata = DATA_W'($urandom);
    r = int'($urandom_range(0, 9));
    if (r < 6)       next_w = int'($urandom_range(0, 3));
    else if (r == 6) next_w = TIMEOUT - 1;
    else if (r == 7) next_w = TIMEOUT + 2;
    else             next_w = 0;
  endtask

  // One cycle: check the previous edge's outputs, then drive the next inputs.
  task automatic applyStimulus();
    @(negedge pClk);
    checkAll();
    if (m_busy && m_k == 1) bus.cmd_valid = 1'b0;
    if (m_busy && m_k >= 2 && m_k <= 1 + m_en) bus.pReady = (m_k == m_w + 2);
    else bus.pReady = 1'($urandom_range(0, 1));
    if (rand_mode) begin
      bus.pReadData = DATA_W'($urandom);
      bus.pSlvErr   = ($urandom_range(0, 3) == 0);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if (!bus.cmd_valid && $urandom_range(0, 2) == 0) newRandomCmd();
    end else begin
      bus.pReadData = dir_rdata;
      bus.pSlvErr   = dir_slverr;
      bus.rsp_ready = dir_rsp_ready;
    end
  endtask

  task automatic runDirected(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input int w,
                             input logic [DATA_W-1:0] rdata, input logic slverr,
                             output int sel_cnt, output int en_cnt, output int lat,
                             output logic [DATA_W-1:0] got_rdata,
                             output logic got_err, output logic got_to);
    bit seen;
    sel_cnt = 0; en_cnt = 0; lat = 0; seen = 1'b0;
    got_rdata = 'x; got_err = 1'bx; got_to = 1'bx;
    dir_rdata = rdata; dir_slverr = slverr; dir_rsp_ready = 1'b1;
    bus.pReadData = rdata; bus.pSlvErr = slverr; bus.rsp_ready = 1'b1;
    bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    next_w = w; bus.cmd_valid = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      applyStimulus();
      if (bus.pSel) sel_cnt++;
      if (bus.pEnable) en_cnt++;
      if (bus.rsp_valid && lat == 0) begin
        lat = i; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err; got_to = bus.rsp_timeout;
      end
      if (m_busy) seen = 1'b1;
      if (seen && !m_busy) break;
    end
    checkOutput("directed_done", 64'(seen && !m_busy), 64'd1);
  endtask

  initial begin
    int sel_c, en_c, lat_c, gap;
    logic [DATA_W-1:0] rd;
    logic er, to;

    pReset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.pReadData = '0; bus.pReady = 1'b0; bus.pSlvErr = 1'b0;
    #2 pReset = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("rst_pSel",      64'(bus.pSel),      64'd0);
    checkOutput("rst_pEnable",   64'(bus.pEnable),   64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_busy",      64'(bus.busy),      64'd0);
    checkOutput("rst_pAddr",     64'(bus.pAddr),     64'd0);
    checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(negedge pClk);
    #2 pReset = 1'b1;

    // Zero-wait write
    runDirected(1'b1, 32'd0, 32'd10, 0, 32'h0, 1'b0, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("t1_sel_cycles", 64'(sel_c), 64'd2);
    checkOutput("t1_en_cycles",  64'(en_c),  64'd1);
    checkOutput("t1_rsp_lat",    64'(lat_c), 64'd3);
    checkOutput("t1_rdata",      64'(rd),    64'd0);
    checkOutput("t1_err",        64'(er),    64'd0);
    checkOutput("t1_pWdata",     64'(bus.pWdata), 64'd10);
    checkOutput("t1_pWrite",     64'(bus.pWrite), 64'd1);

    // Read answered on the third ACCESS cycle
    runDirected(1'b0, 32'd1, 32'd0, 2, 32'h14, 1'b0, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("t2_en_cycles", 64'(en_c), 64'd3);
    checkOutput("t2_rdata",     64'(rd),   64'h14);
    checkOutput("t2_err",       64'(er),   64'd0);
    checkOutput("t2_pAddr",     64'(bus.pAddr), 64'd1);

    // Slave error, then a clean read
    runDirected(1'b1, 32'd3, 32'h00FFFF00, 0, 32'h1234, 1'b1, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("t3_err",     64'(er), 64'd1);
    checkOutput("t3_timeout", 64'(to), 64'd0);
    checkOutput("t3_rdata",   64'(rd), 64'd0);
    runDirected(1'b0, 32'd2, 32'd0, 1, 32'h55, 1'b0, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("t3b_rdata", 64'(rd), 64'h55);
    checkOutput("t3b_err",   64'(er), 64'd0);
    checkOutput("t3b_en",    64'(en_c), 64'd2);

    // Timeout
    runDirected(1'b0, 32'd4, 32'd0, TIMEOUT + 4, 32'hDEAD, 1'b0, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("t4_en_cycles",  64'(en_c),  64'd16);
    checkOutput("t4_sel_cycles", 64'(sel_c), 64'd17);
    checkOutput("t4_rdata",      64'(rd),    64'd0);
    checkOutput("t4_err",        64'(er),    64'd1);
    checkOutput("t4_timeout",    64'(to),    64'd1);

    // pReady on the last permitted ACCESS cycle still completes normally
    runDirected(1'b0, 32'd9, 32'd0, TIMEOUT - 1, 32'h77, 1'b0, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("tb_en_cycles", 64'(en_c), 64'd16);
    checkOutput("tb_rdata",     64'(rd),   64'h77);
    checkOutput("tb_timeout",   64'(to),   64'd0);

    // Backpressure with a second command waiting
    dir_rsp_ready = 1'b0; dir_rdata = 32'hABCD; dir_slverr = 1'b0;
    bus.rsp_ready = 1'b0; bus.pReadData = 32'hABCD; bus.pSlvErr = 1'b0;
    bus.cmd_write = 1'b0; bus.cmd_addr = 32'd5; next_w = 0; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10 && !(m_busy && m_k == 2 + m_en); i++) applyStimulus();
    bus.cmd_write = 1'b1; bus.cmd_addr = 32'd6; bus.cmd_wdata = 32'h99; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'hABCD);
      checkOutput("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      checkOutput("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    end
    dir_rsp_ready = 1'b1; bus.rsp_ready = 1'b1;
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus();
      if (bus.pSel && gap == 0) gap = i;
    end
    checkOutput("bp_second_setup", 64'(gap), 64'd2);
    for (int i = 0; i < 40 && m_busy; i++) applyStimulus();

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) applyStimulus();
    rand_mode = 1'b0; dir_rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && m_busy; i++) applyStimulus();
    checkOutput("drain_idle", 64'(m_busy), 64'd0);

    // Reset while in ACCESS
    bus.cmd_write = 1'b0; bus.cmd_addr = 32'd7; next_w = TIMEOUT + 4; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10 && !(m_busy && m_k >= 2 && m_k <= 1 + m_en); i++) applyStimulus();
    checkOutput("r_pEnable_before", 64'(bus.pEnable), 64'd1);
    #2 pReset = 1'b0;
    #1;
    checkOutput("r_pSel",      64'(bus.pSel),      64'd0);
    checkOutput("r_pEnable",   64'(bus.pEnable),   64'd0);
    checkOutput("r_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("r_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("r_busy",      64'(bus.busy),      64'd0);
    bus.cmd_valid = 1'b0;
    @(negedge pClk);
    #2 pReset = 1'b1;
    runDirected(1'b1, 32'd8, 32'h5A, 0, 32'h0, 1'b0, sel_c, en_c, lat_c, rd, er, to);
    checkOutput("r_after_lat",    64'(lat_c),      64'd3);
    checkOutput("r_after_err",    64'(er),         64'd0);
    checkOutput("r_after_pWdata", 64'(bus.pWdata), 64'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
